// File: rtl/rr_arb_mux_4_1.sv
// Four-channel round-robin arbiter with integrated 4:1 data select and a registered output stage.
// Optional burst mode (a channel may hold its grant for up to MAX_BURST transfers): define RR_ARB_MUX_4_1_BURST_EN.
module rr_arb_mux_4_1 #(
  parameter int unsigned WIDTH     = 4,
  parameter int unsigned MAX_BURST = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [4*WIDTH-1:0] in_data,
  input  logic [3:0]         in_valid,
  output logic [3:0]         in_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic [1:0]         out_sel,
  output logic               out_valid,
  input  logic               out_ready
);

  localparam int unsigned NCH = 4;

  if (MAX_BURST < 1 || MAX_BURST > 15) begin : g_bad_max_burst
    $error("rr_arb_mux_4_1: MAX_BURST must be in 1..15");
  end

  logic [1:0]       ptr;
  logic [1:0]       start;
  logic [1:0]       gnt;
  logic             gnt_vld;
  logic             load_en;
  logic             xfer;
  logic [WIDTH-1:0] sel_data;

  // Reset gating keeps in_ready low while the block is held in reset.
  assign load_en = rst_n && (!out_valid || out_ready);
  assign xfer    = load_en && gnt_vld;

  // Rotating-priority scan: descending loop so the lowest offset from start wins.
  always_comb begin
    logic [1:0] idx;
    gnt_vld = 1'b0;
    gnt     = start;
    idx     = start;
    for (int k = NCH - 1; k >= 0; k--) begin
      idx = start + 2'(k);
      if (in_valid[idx]) begin
        gnt_vld = 1'b1;
        gnt     = idx;
      end
    end
  end

  always_comb begin
    in_ready = '0;
    if (xfer) in_ready[gnt] = 1'b1;
  end

  // Only the granted channel's slice is ever routed, so X on other channels cannot leak.
  always_comb begin
    sel_data = '0;
    for (int k = 0; k < NCH; k++) begin
      if (2'(k) == gnt) sel_data = in_data[k*WIDTH +: WIDTH];
    end
  end

`ifdef RR_ARB_MUX_4_1_BURST_EN
  logic [3:0] bcnt;
  logic       brk;
  logic [3:0] bcnt_base;
  logic [3:0] bcnt_nxt;
  logic       keep;

  // A burst breaks when the channel holding priority drops valid mid-burst.
  assign brk       = (bcnt != 4'd0) && !in_valid[ptr];
  assign start     = brk ? ptr + 2'd1 : ptr;
  assign bcnt_base = (!brk && gnt == ptr) ? bcnt : 4'd0;
  assign bcnt_nxt  = bcnt_base + 4'd1;
  assign keep      = 32'(bcnt_nxt) < MAX_BURST;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr  <= 2'd0;
      bcnt <= 4'd0;
    end else if (xfer) begin
      if (keep) begin
        ptr  <= gnt;
        bcnt <= bcnt_nxt;
      end else begin
        ptr  <= gnt + 2'd1;
        bcnt <= 4'd0;
      end
    end else if (load_en && brk) begin
      ptr  <= ptr + 2'd1;
      bcnt <= 4'd0;
    end
  end
`else
  assign start = ptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= 2'd0;
    end else if (xfer) begin
      ptr <= gnt + 2'd1;
    end
  end
`endif

  // Output register: refilled on transfer, emptied when drained with nothing to load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= 2'd0;
    end else if (xfer) begin
      out_valid <= 1'b1;
      out_data  <= sel_data;
      out_sel   <= gnt;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rr_arb_mux_4_1.sv
// Directed, table-driven bench for rr_arb_mux_4_1 with hand-computed expectations.
module tb_rr_arb_mux_4_1;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] in_data;
  logic [3:0]  in_valid;
  logic [3:0]  in_ready;
  logic [3:0]  out_data;
  logic [1:0]  out_sel;
  logic        out_valid;
  logic        out_ready;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic [3:0]  v;
    logic [15:0] d;
    logic        ord;
    logic [3:0]  erdy;
    logic        evld;
    logic [1:0]  esel;
    logic [3:0]  edat;
  } vec_t;

  vec_t tbl[$];

  localparam logic [15:0] DALL = 16'hD3BA;  // ch3=D ch2=3 ch1=B ch0=A
  localparam logic [15:0] DX   = 16'hx3BA;  // ch3 data unknown

  always #5 clk = ~clk;

  rr_arb_mux_4_1 #(.WIDTH(4), .MAX_BURST(2)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .out_data(out_data), .out_sel(out_sel),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  task automatic chk(input string name, input int idx, input logic [15:0] act, input logic [15:0] exp);
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s vec%0d: got %h expected %h", name, idx, act, exp);
    end
  endtask

  task automatic add(input logic [3:0] v, input logic [15:0] d, input logic ord,
                     input logic [3:0] erdy, input logic evld, input logic [1:0] esel,
                     input logic [3:0] edat);
    vec_t t;
    t.v = v; t.d = d; t.ord = ord; t.erdy = erdy; t.evld = evld; t.esel = esel; t.edat = edat;
    tbl.push_back(t);
  endtask

  // Drive at the falling edge, check in_ready before the rising edge, outputs after it.
  task automatic apply(input vec_t t, input int idx);
    in_valid  = t.v;
    in_data   = t.d;
    out_ready = t.ord;
    #1;
    chk("in_ready", idx, 16'(in_ready), 16'(t.erdy));
    @(posedge clk);
    @(negedge clk);
    chk("out_valid", idx, 16'(out_valid), 16'(t.evld));
    chk("out_sel", idx, 16'(out_sel), 16'(t.esel));
    chk("out_data", idx, 16'(out_data), 16'(t.edat));
    if ($isunknown(out_data)) begin
      miscompares++;
      $display("FAIL out_data_x vec%0d: got %h expected known value", idx, out_data);
    end
    vectors++;
  endtask

  initial begin
    vec_t t;
`ifdef RR_ARB_MUX_4_1_BURST_EN
    // MAX_BURST=2, all valid: each channel gets two consecutive grants.
    add(4'hF, DALL, 1'b1, 4'b0001, 1'b1, 2'd0, 4'hA);
    add(4'hF, DALL, 1'b1, 4'b0001, 1'b1, 2'd0, 4'hA);
    add(4'hF, DALL, 1'b1, 4'b0010, 1'b1, 2'd1, 4'hB);
    add(4'hF, DALL, 1'b1, 4'b0010, 1'b1, 2'd1, 4'hB);
    add(4'hF, DALL, 1'b1, 4'b0100, 1'b1, 2'd2, 4'h3);
    add(4'hF, DALL, 1'b1, 4'b0100, 1'b1, 2'd2, 4'h3);
    add(4'hF, DALL, 1'b1, 4'b1000, 1'b1, 2'd3, 4'hD);
    add(4'hF, DALL, 1'b1, 4'b1000, 1'b1, 2'd3, 4'hD);
    // ch0 starts a burst, then drops valid: burst ends and ch1 takes over.
    add(4'hF, DALL, 1'b1, 4'b0001, 1'b1, 2'd0, 4'hA);
    add(4'hE, DALL, 1'b1, 4'b0010, 1'b1, 2'd1, 4'hB);
    add(4'hF, DALL, 1'b1, 4'b0010, 1'b1, 2'd1, 4'hB);
    add(4'hF, DALL, 1'b1, 4'b0100, 1'b1, 2'd2, 4'h3);
`else
    // Round robin, all valid: 0,1,2,3,0,1,2,3.
    for (int r = 0; r < 2; r++) begin
      add(4'hF, DALL, 1'b1, 4'b0001, 1'b1, 2'd0, 4'hA);
      add(4'hF, DALL, 1'b1, 4'b0010, 1'b1, 2'd1, 4'hB);
      add(4'hF, DALL, 1'b1, 4'b0100, 1'b1, 2'd2, 4'h3);
      add(4'hF, DALL, 1'b1, 4'b1000, 1'b1, 2'd3, 4'hD);
    end
    // Sparse after ch3 grant: ch1 then ch2.
    add(4'h6, DALL, 1'b1, 4'b0010, 1'b1, 2'd1, 4'hB);
    add(4'h6, DALL, 1'b1, 4'b0100, 1'b1, 2'd2, 4'h3);
    // Only ch0 valid: granted, then granted again after its own grant.
    add(4'h1, DALL, 1'b1, 4'b0001, 1'b1, 2'd0, 4'hA);
    add(4'h1, DALL, 1'b1, 4'b0001, 1'b1, 2'd0, 4'hA);
    // Backpressure: 3 stalled cycles hold everything, then ch1 follows.
    for (int s = 0; s < 3; s++) add(4'hF, DALL, 1'b0, 4'b0000, 1'b1, 2'd0, 4'hA);
    add(4'hF, DALL, 1'b1, 4'b0010, 1'b1, 2'd1, 4'hB);
    // Drain with no valid, then idle with out_ready low.
    add(4'h0, DALL, 1'b1, 4'b0000, 1'b0, 2'd1, 4'hB);
    add(4'h0, DALL, 1'b0, 4'b0000, 1'b0, 2'd1, 4'hB);
    // ptr=2, only ch3 valid.
    add(4'h8, DALL, 1'b1, 4'b1000, 1'b1, 2'd3, 4'hD);
    // X on ch3 data with ch3 not valid.
    for (int r = 0; r < 2; r++) begin
      add(4'h7, DX, 1'b1, 4'b0001, 1'b1, 2'd0, 4'hA);
      add(4'h7, DX, 1'b1, 4'b0010, 1'b1, 2'd1, 4'hB);
      add(4'h7, DX, 1'b1, 4'b0100, 1'b1, 2'd2, 4'h3);
    end
`endif

    // Reset held with all channels valid.
    rst_n = 1'b0; in_valid = 4'hF; in_data = DALL; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", -1, 16'(in_ready), 16'h0);
    chk("rst_out_valid", -1, 16'(out_valid), 16'h0);
    chk("rst_out_data", -1, 16'(out_data), 16'h0);
    chk("rst_out_sel", -1, 16'(out_sel), 16'h0);
    vectors++;
    rst_n = 1'b1;

    foreach (tbl[i]) apply(tbl[i], i);

    // Asynchronous reset mid-transfer discards the held word.
    t.v = 4'hF; t.d = DALL; t.ord = 1'b0; t.erdy = 4'b0000; t.evld = 1'b1;
    t.esel = out_sel; t.edat = out_data;
    if (out_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL pre_midrst_valid: got %b expected 1", out_valid);
    end
    in_valid = 4'hF; out_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", -2, 16'(out_valid), 16'h0);
    chk("midrst_out_data", -2, 16'(out_data), 16'h0);
    chk("midrst_out_sel", -2, 16'(out_sel), 16'h0);
    chk("midrst_in_ready", -2, 16'(in_ready), 16'h0);
    vectors++;
    @(negedge clk);
    rst_n = 1'b1;
    t.ord = 1'b1; t.erdy = 4'b0001; t.evld = 1'b1; t.esel = 2'd0; t.edat = 4'hA;
    apply(t, 1000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
